// File: rtl/vme_bus_arbiter.sv
// Round-robin arbiter that shares one VME register-bank slave port between two requesters, with a watchdog.
// Master strobe at cycle N gives a slave strobe at N+2. Slave done at cycle M gives a master done at M+1.
module vme_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [17:0] m0_addr,
   input  logic [31:0] m0_wrdata,
   input  logic        m0_rdmem,
   input  logic        m0_wrmem,
   output logic [31:0] m0_rddata,
   output logic        m0_rddone,
   output logic        m0_wrdone,
   output logic        m0_rderror,
   output logic        m0_wrerror,
   input  logic [17:0] m1_addr,
   input  logic [31:0] m1_wrdata,
   input  logic        m1_rdmem,
   input  logic        m1_wrmem,
   output logic [31:0] m1_rddata,
   output logic        m1_rddone,
   output logic        m1_wrdone,
   output logic        m1_rderror,
   output logic        m1_wrerror,
   output logic [17:0] VMEAddr,
   output logic [31:0] VMEWrData,
   output logic        VMERdMem,
   output logic        VMEWrMem,
   input  logic [31:0] VMERdData,
   input  logic        VMERdDone,
   input  logic        VMEWrDone,
   input  logic        VMERdError,
   input  logic        VMEWrError,
   output logic [15:0] timeout_count
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_pend;
   logic [1:0]        r_is_wr;
   logic [1:0][17:0]  r_addr;
   logic [1:0][31:0]  r_wdat;
   logic              r_own;
   logic              r_cur_wr;
   logic              r_last;
   logic [15:0]       r_wdog;

   logic [1:0]        w_stb;
   logic [1:0]        w_wr;
   logic [1:0][17:0]  w_addr;
   logic [1:0][31:0]  w_wdat;
   logic [1:0]        w_active;
   logic [1:0]        w_cap;
   logic              w_grant;
   logic              w_sel;
   logic              w_done;
   logic              w_tmo;
   logic              w_fin;
   logic              w_slv_done;
   logic              w_slv_err;
   logic              w_err;
   logic [31:0]       w_data;
   logic [15:0]       w_wdog_inc;

   assign w_stb      = {m1_rdmem | m1_wrmem, m0_rdmem | m0_wrmem};
   assign w_wr       = {m1_wrmem, m0_wrmem};
   assign w_addr     = {m1_addr, m0_addr};
   assign w_wdat     = {m1_wrdata, m0_wrdata};
   assign w_active   = {(r_state == S_WAIT) && r_own, (r_state == S_WAIT) && !r_own};
   assign w_cap      = w_stb & ~r_pend & ~w_active;
   assign w_slv_done = r_cur_wr ? VMEWrDone : VMERdDone;
   assign w_slv_err  = r_cur_wr ? VMEWrError : VMERdError;
   assign w_wdog_inc = r_wdog + 16'd1;
   assign w_fin      = w_done | w_tmo;
   assign w_err      = w_tmo | w_slv_err;
   assign w_data     = w_tmo ? TIMEOUT_DATA : VMERdData;

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_sel       = 1'b0;
      w_done      = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_pend) begin
               w_grant     = 1'b1;
               // On a tie the master not granted last wins
               w_sel       = (&r_pend) ? !r_last : r_pend[1];
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_slv_done) begin
               w_done      = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_wdog_inc == TO_LIMIT) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state       <= S_IDLE;
         r_pend        <= '0;
         r_is_wr       <= '0;
         r_addr        <= '0;
         r_wdat        <= '0;
         r_own         <= 1'b0;
         r_cur_wr      <= 1'b0;
         r_last        <= 1'b1;
         r_wdog        <= '0;
         VMEAddr       <= '0;
         VMEWrData     <= '0;
         VMERdMem      <= 1'b0;
         VMEWrMem      <= 1'b0;
         m0_rddata     <= '0;
         m0_rddone     <= 1'b0;
         m0_wrdone     <= 1'b0;
         m0_rderror    <= 1'b0;
         m0_wrerror    <= 1'b0;
         m1_rddata     <= '0;
         m1_rddone     <= 1'b0;
         m1_wrdone     <= 1'b0;
         m1_rderror    <= 1'b0;
         m1_wrerror    <= 1'b0;
         timeout_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         VMERdMem   <= 1'b0;
         VMEWrMem   <= 1'b0;
         m0_rddone  <= 1'b0;
         m0_wrdone  <= 1'b0;
         m0_rderror <= 1'b0;
         m0_wrerror <= 1'b0;
         m1_rddone  <= 1'b0;
         m1_wrdone  <= 1'b0;
         m1_rderror <= 1'b0;
         m1_wrerror <= 1'b0;

         for (int m = 0; m < 2; m++) begin
            if (w_cap[m]) begin
               r_pend[m]  <= 1'b1;
               r_is_wr[m] <= w_wr[m];
               r_addr[m]  <= w_addr[m];
               r_wdat[m]  <= w_wdat[m];
            end
         end

         if (w_grant) begin
            r_pend[w_sel] <= 1'b0;
            r_own         <= w_sel;
            r_last        <= w_sel;
            r_cur_wr      <= r_is_wr[w_sel];
            VMEAddr       <= r_addr[w_sel];
            VMEWrData     <= r_wdat[w_sel];
            VMEWrMem      <= r_is_wr[w_sel];
            VMERdMem      <= !r_is_wr[w_sel];
            r_wdog        <= '0;
         end

         if (r_state == S_WAIT && !w_fin)
            r_wdog <= w_wdog_inc;

         if (w_fin) begin
            if (!r_own) begin
               if (r_cur_wr) begin
                  m0_wrdone  <= 1'b1;
                  m0_wrerror <= w_err;
               end else begin
                  m0_rddone  <= 1'b1;
                  m0_rderror <= w_err;
                  m0_rddata  <= w_data;
               end
            end else begin
               if (r_cur_wr) begin
                  m1_wrdone  <= 1'b1;
                  m1_wrerror <= w_err;
               end else begin
                  m1_rddone  <= 1'b1;
                  m1_rderror <= w_err;
                  m1_rddata  <= w_data;
               end
            end
         end

         if (w_tmo && timeout_count != 16'hFFFF)
            timeout_count <= timeout_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Scoreboard bench for vme_bus_arbiter: directed requests, a scripted slave model and a done-pulse monitor.
module tb_vme_bus_arbiter;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [17:0] m0_addr, m1_addr;
   logic [31:0] m0_wrdata, m1_wrdata;
   logic        m0_rdmem, m0_wrmem, m1_rdmem, m1_wrmem;
   logic [31:0] m0_rddata, m1_rddata;
   logic        m0_rddone, m0_wrdone, m0_rderror, m0_wrerror;
   logic        m1_rddone, m1_wrdone, m1_rderror, m1_wrerror;
   logic [17:0] VMEAddr;
   logic [31:0] VMEWrData;
   logic        VMERdMem, VMEWrMem;
   logic [31:0] VMERdData;
   logic        VMERdDone, VMEWrDone, VMERdError, VMEWrError;
   logic [15:0] timeout_count;

   vme_bus_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
      .Clk(Clk), .Rst(Rst),
      .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_rdmem(m0_rdmem), .m0_wrmem(m0_wrmem),
      .m0_rddata(m0_rddata), .m0_rddone(m0_rddone), .m0_wrdone(m0_wrdone),
      .m0_rderror(m0_rderror), .m0_wrerror(m0_wrerror),
      .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_rdmem(m1_rdmem), .m1_wrmem(m1_wrmem),
      .m1_rddata(m1_rddata), .m1_rddone(m1_rddone), .m1_wrdone(m1_wrdone),
      .m1_rderror(m1_rderror), .m1_wrerror(m1_wrerror),
      .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
      .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
      .VMERdError(VMERdError), .VMEWrError(VMEWrError),
      .timeout_count(timeout_count)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic        mst;
      logic        wr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic        wr;
      logic [17:0] addr;
      logic [31:0] wd;
   } slv_t;

   exp_t exp_q[$];
   slv_t slv_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Slave behaviour knobs; read data returned is sl_data ^ address
   logic        sl_silent = 1'b0;
   logic        sl_err    = 1'b0;
   logic [31:0] sl_data   = 32'h0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic push_exp(input logic mst, input logic wr, input logic [31:0] d, input logic e);
      exp_t x;
      x.mst = mst; x.wr = wr; x.data = d; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic push_slv(input logic wr, input logic [17:0] a, input logic [31:0] d);
      slv_t s;
      s.wr = wr; s.addr = a; s.wd = d;
      slv_q.push_back(s);
   endtask

   task automatic strobe(input logic r0, input logic w0, input logic r1, input logic w1,
                         input logic [17:0] a0, input logic [17:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
      @(posedge Clk); #1;
      m0_addr = a0; m0_wrdata = d0; m0_rdmem = r0; m0_wrmem = w0;
      m1_addr = a1; m1_wrdata = d1; m1_rdmem = r1; m1_wrmem = w1;
      @(posedge Clk); #1;
      m0_rdmem = 1'b0; m0_wrmem = 1'b0; m1_rdmem = 1'b0; m1_wrmem = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((exp_q.size() != 0 || slv_q.size() != 0) && t < 80) begin
         @(posedge Clk);
         t++;
      end
      repeat (2) @(posedge Clk);
      #1;
      check(nm, 32'(exp_q.size() + slv_q.size()), 32'd0);
   endtask

   // Slave model: checks each strobe and answers one cycle later unless silent
   initial begin
      slv_t s;
      VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdError = 1'b0; VMEWrError = 1'b0;
      forever begin
         @(negedge Clk);
         if (VMERdMem || VMEWrMem) begin
            check("slv_one_strobe", 32'(VMERdMem & VMEWrMem), 32'd0);
            if (slv_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL slv_unexpected: got strobe addr %h, required none", VMEAddr);
            end else begin
               s = slv_q.pop_front();
               check("slv_type", 32'(VMEWrMem), 32'(s.wr));
               check("slv_addr", 32'(VMEAddr), 32'(s.addr));
               if (s.wr) check("slv_wrdata", VMEWrData, s.wd);
            end
            if (!sl_silent) begin
               @(posedge Clk); #1;
               if (VMEWrMem || (slv_q.size() >= 0 && s.wr)) begin
                  VMEWrDone = 1'b1; VMEWrError = sl_err;
               end else begin
                  VMERdDone = 1'b1; VMERdError = sl_err; VMERdData = sl_data ^ {14'h0, VMEAddr};
               end
               @(posedge Clk); #1;
               VMERdDone = 1'b0; VMEWrDone = 1'b0; VMERdError = 1'b0; VMEWrError = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every master done pulse
   initial begin
      exp_t e;
      logic mst, wr, err;
      logic [31:0] dat;
      forever begin
         @(negedge Clk);
         if (m0_rddone | m0_wrdone | m1_rddone | m1_wrdone) begin
            mst = m1_rddone | m1_wrdone;
            wr  = m0_wrdone | m1_wrdone;
            err = mst ? (wr ? m1_wrerror : m1_rderror) : (wr ? m0_wrerror : m0_rderror);
            dat = mst ? m1_rddata : m0_rddata;
            check("done_onehot", 32'($countones({m0_rddone, m0_wrdone, m1_rddone, m1_wrdone})), 32'd1);
            check("other_err", 32'(mst ? {m0_rderror, m0_wrerror} : {m1_rderror, m1_wrerror}), 32'd0);
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_done: got done from master %0d, required none", mst);
            end else begin
               e = exp_q.pop_front();
               check("done_master", 32'(mst), 32'(e.mst));
               check("done_type", 32'(wr), 32'(e.wr));
               check("done_err", 32'(err), 32'(e.err));
               if (!e.wr) check("rd_data", dat, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, required end within bound");
      $fatal(1, "bench timed out");
   end

   initial begin
      Rst = 1'b1;
      m0_addr = '0; m0_wrdata = '0; m0_rdmem = 1'b0; m0_wrmem = 1'b0;
      m1_addr = '0; m1_wrdata = '0; m1_rdmem = 1'b0; m1_wrmem = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      check("reset_ctl", 32'({VMERdMem, VMEWrMem, m0_rddone, m0_wrdone, m1_rddone, m1_wrdone}), 32'd0);
      check("reset_tocnt", 32'(timeout_count), 32'd0);

      // m0 write with exact latency checks
      push_slv(1'b1, 18'h00001, 32'h12345678);
      push_exp(1'b0, 1'b1, 32'h0, 1'b0);
      strobe(1'b0, 1'b1, 1'b0, 1'b0, 18'h00001, 18'h0, 32'h12345678, 32'h0);
      @(negedge Clk); check("lat_n1_wrmem", 32'(VMEWrMem), 32'd0);
      @(negedge Clk); check("lat_n2_wrmem", 32'(VMEWrMem), 32'd1);
      @(negedge Clk); check("lat_n3_wrdone", 32'(m0_wrdone), 32'd0);
      @(negedge Clk); check("lat_n4_wrdone", 32'(m0_wrdone), 32'd1);
      check("m1_quiet", 32'({m1_rddone, m1_wrdone, m1_rderror, m1_wrerror}), 32'd0);
      check("m1_rddata_quiet", m1_rddata, 32'd0);
      drain("drain_t1");

      // m1 read answered with error
      sl_data = 32'hA5A5A5A5; sl_err = 1'b1;
      push_slv(1'b0, 18'h00000, 32'h0);
      push_exp(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
      strobe(1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 18'h00000, 32'h0, 32'h0);
      drain("drain_t2");

      // simultaneous reads, m1 granted last: m0 first
      sl_data = 32'h11110000; sl_err = 1'b0;
      push_slv(1'b0, 18'h00010, 32'h0);
      push_slv(1'b0, 18'h00020, 32'h0);
      push_exp(1'b0, 1'b0, 32'h11110010, 1'b0);
      push_exp(1'b1, 1'b0, 32'h11110020, 1'b0);
      strobe(1'b1, 1'b0, 1'b1, 1'b0, 18'h00010, 18'h00020, 32'h0, 32'h0);
      drain("drain_t3");

      // rd+wr together is a write; a strobe while pending is dropped
      push_slv(1'b1, 18'h00030, 32'hCAFEF00D);
      push_exp(1'b0, 1'b1, 32'h0, 1'b0);
      @(posedge Clk); #1;
      m0_addr = 18'h00030; m0_wrdata = 32'hCAFEF00D; m0_rdmem = 1'b1; m0_wrmem = 1'b1;
      @(posedge Clk); #1;
      m0_addr = 18'h00031; m0_wrdata = 32'h0; m0_wrmem = 1'b0;
      @(posedge Clk); #1;
      m0_rdmem = 1'b0;
      drain("drain_t4");

      // simultaneous writes after m0 was last: m1 first
      push_slv(1'b1, 18'h00050, 32'h0000BBBB);
      push_slv(1'b1, 18'h00040, 32'h0000AAAA);
      push_exp(1'b1, 1'b1, 32'h0, 1'b0);
      push_exp(1'b0, 1'b1, 32'h0, 1'b0);
      strobe(1'b0, 1'b1, 1'b0, 1'b1, 18'h00040, 18'h00050, 32'h0000AAAA, 32'h0000BBBB);
      drain("drain_t5");

      // silent slave: watchdog aborts the read
      sl_silent = 1'b1;
      push_slv(1'b0, 18'h00060, 32'h0);
      push_exp(1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, 18'h00060, 18'h0, 32'h0, 32'h0);
      drain("drain_t6");
      check("tocnt_after_timeout", 32'(timeout_count), 32'd1);
      sl_silent = 1'b0;

      // next request after a timeout proceeds normally
      push_slv(1'b1, 18'h00070, 32'h77777777);
      push_exp(1'b1, 1'b1, 32'h0, 1'b0);
      strobe(1'b0, 1'b0, 1'b0, 1'b1, 18'h0, 18'h00070, 32'h0, 32'h77777777);
      drain("drain_t7");

      // reset while waiting on the slave: transaction abandoned
      sl_silent = 1'b1;
      push_slv(1'b0, 18'h00080, 32'h0);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, 18'h00080, 18'h0, 32'h0, 32'h0);
      @(posedge Clk); #1 Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
      @(negedge Clk);
      check("rst_ctl", 32'({VMERdMem, VMEWrMem, m0_rddone, m0_wrdone, m0_rderror, m0_wrerror,
                            m1_rddone, m1_wrdone, m1_rderror, m1_wrerror}), 32'd0);
      check("rst_addr", 32'(VMEAddr), 32'd0);
      check("rst_m0_rddata", m0_rddata, 32'd0);
      check("rst_m1_rddata", m1_rddata, 32'd0);
      check("rst_tocnt", 32'(timeout_count), 32'd0);
      check("rst_slv_seen", 32'(slv_q.size()), 32'd0);
      sl_silent = 1'b0;
      repeat (8) @(posedge Clk);

      // fresh m1 read after reset
      push_slv(1'b0, 18'h00090, 32'h0);
      push_exp(1'b1, 1'b0, 32'h11110090, 1'b0);
      strobe(1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 18'h00090, 32'h0, 32'h0);
      drain("drain_t8");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vme_bus_arbiter.md
Name: vme_bus_arbiter

Overview:
- Shares one VME-style register-bank slave port between two requesters, m0 (host VME decoder) and m1 (local sequencer).
- The slave side uses the same strobe/done protocol as the generated register banks: VMEAddr, VMERdMem/VMEWrMem, VMERdDone/VMEWrDone, VMERdError/VMEWrError.
- Grants one transaction at a time using round-robin arbitration, then routes done, error and read data back to the owning requester.
- A watchdog terminates transactions the slave never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 255: wait-state cycles before a transaction is aborted with error; legal range 1..65535.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on a timed-out read.

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset; synchronous, active-high
- m0_addr / m1_addr  in  18  word address, bits [19:2]
- m0_wrdata / m1_wrdata  in  32  write data
- m0_rdmem / m1_rdmem  in  1  single-cycle read strobe
- m0_wrmem / m1_wrmem  in  1  single-cycle write strobe
- m0_rddata / m1_rddata  out  32  read data, valid with rddone
- m0_rddone / m1_rddone / m0_wrdone / m1_wrdone  out  1  one-cycle completion pulses
- m0_rderror / m1_rderror / m0_wrerror / m1_wrerror  out  1  error flags, valid with the matching done pulse
- VMEAddr  out  18  slave address
- VMEWrData  out  32  slave write data
- VMERdMem / VMEWrMem  out  1  slave strobes, one cycle per transaction
- VMERdData  in  32  slave read data
- VMERdDone / VMEWrDone / VMERdError / VMEWrError  in  1  slave completion and error
- timeout_count  out  16  saturating count of timed-out transactions

Behaviour:
- Reset (Rst=1 at a Clk edge): every output register goes to 0, FSM to IDLE, pending flags cleared, round-robin pointer set so m0 wins the first tie, timeout_count=0. A transaction in flight is abandoned; no done is generated for it.
- Request capture:
  - A master strobe sets a pending flag and latches addr, wrdata and type, unless that master already has a pending or active transaction; then the strobe is ignored.
  - rdmem and wrmem asserted together = write only; the read is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any master is pending, grant it. If both are pending, grant the master other than the last one granted.
  - On grant: drive VMEAddr/VMEWrData from the latch, pulse VMERdMem or VMEWrMem for exactly one cycle (registered), clear the pending flag, clear the watchdog, go to WAIT.
  - Latency: master strobe at cycle N gives a slave strobe at N+2 when the bus is idle.
- WAIT:
  - Only the done matching the issued type counts; the other done and any done seen in IDLE/RESP are ignored.
  - On matching done: capture VMERdData and the error bit, go to RESP.
  - Otherwise increment the watchdog. When it equals TIMEOUT_CYCLES: error=1, data=TIMEOUT_DATA (reads), timeout_count+1 (saturates at 65535), go to RESP.
  - The slave must not complete a transaction after it has timed out.
- RESP:
  - Pulse the granted master's matching done for one cycle, with error and rddata. The other master's outputs stay 0. rddata holds its value until the next read completion for that master.
  - Return to IDLE. Slave done at cycle M gives master done at M+1.
  - Minimum spacing between slave strobes = 4 cycles (one-cycle slave done).
- Write data and address on VMEAddr/VMEWrData are held stable from the strobe until RESP.
- A master may strobe again in the cycle its done is asserted; that strobe is captured.

Test Plan:
- m0 write addr 0x00001 data 0x12345678, slave WrDone 1 cycle after strobe -> VMEWrMem pulse at N+2, m0_wrdone at N+4, m1 outputs stay 0.
- m0 and m1 read in the same cycle, m1 granted last -> m0 served first, then m1; a repeat simultaneous pair serves m1 first, then m0.
- m1 read, slave returns VMERdData=0xA5A5A5A5 with VMERdError=1 -> m1_rddone with m1_rddata=0xA5A5A5A5 and m1_rderror=1.
- TIMEOUT_CYCLES=4, slave silent -> m0_rddone with rderror=1 and data 0xDEADBEEF; timeout_count=1; the next request proceeds normally.
- Rst asserted during WAIT -> no done pulses; all outputs 0 the next cycle; a fresh m1 request is served normally.
- m0 strobes rdmem and wrmem together, then strobes again while pending -> single write issued; the second strobe is ignored.
